// File: rtl/down_timer_if.sv
// Control and status bundle for down_timer; the bench drives the master side and the timer is the slave.
interface down_timer_if #(
  parameter int WIDTH = 4
);
  // load, start and count are sampled on the rising clock edge, with priority load > start > count.
  // There is no valid/ready pair: each input is a single-cycle request that needs no acknowledge.
  // borrow is combinational from count, so a chained timer can use it as its count in the same cycle.
  logic             load;
  logic             start;
  logic             count;
  logic [WIDTH-1:0] ins;
  logic [WIDTH-1:0] state;
  logic             borrow;
  logic             busy;
  logic             done;

  modport master (
    output load, start, count, ins,
    input  state, borrow, busy, done
  );

  modport slave (
    input  load, start, count, ins,
    output state, borrow, busy, done
  );
endinterface

// File: rtl/down_timer.sv
// Loadable, cascadable down-counter timer driven by an upstream tick stream.
// Define DOWN_TIMER_AUTO_RELOAD_EN for periodic mode; one-shot mode is built by default.
module down_timer #(
  parameter int WIDTH = 4
) (
  input logic         clock,
  input logic         reset_n,
  down_timer_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] state_q;
  logic             done_q;
  logic             terminal;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  assign terminal   = (fsm == RUN) && bus.count && (state_q == '0);
  assign bus.borrow = terminal;
  assign bus.busy   = (fsm == RUN);
  assign bus.state  = state_q;
  assign bus.done   = done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm     <= IDLE;
      state_q <= '0;
      done_q  <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      reload  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        // A load aborts any run, even one at its terminal tick, so done stays low.
        fsm     <= IDLE;
        state_q <= bus.ins;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        reload  <= bus.ins;
`endif
      end else begin
        case (fsm)
          IDLE: begin
            if (bus.start) fsm <= RUN;
          end
          RUN: begin
            if (bus.count) begin
              if (state_q != '0) begin
                state_q <= state_q - WIDTH'(1);
              end else begin
                done_q <= 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                state_q <= reload;
`else
                // One-shot: the count stays at zero and a later start re-arms from there.
                fsm <= IDLE;
`endif
              end
            end
          end
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer; the mode test follows DOWN_TIMER_AUTO_RELOAD_EN.
module tb_down_timer;
  localparam int W = 4;

  logic clock;
  logic reset_n;
  int   vec_count;
  int   err_count;

  down_timer_if #(.WIDTH(W)) bus ();

  down_timer #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change on the falling edge; outputs are looked at 1 ns later, well before the next rising edge.
  task automatic drive(input logic l, input logic s, input logic c, input logic [W-1:0] i);
    @(negedge clock);
    bus.load  = l;
    bus.start = s;
    bus.count = c;
    bus.ins   = i;
    #1;
  endtask

  task automatic test_reset;
    // Power-on values while reset is held low.
    vec_count++;
    if (bus.state !== 4'd0) begin err_count++; $display("FAIL por_state: got %0d want 0", bus.state); end
    vec_count++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.borrow !== 1'b0) begin
      err_count++; $display("FAIL por_flags: got busy=%b done=%b borrow=%b want 0 0 0", bus.busy, bus.done, bus.borrow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    // Bring the timer into RUN holding 5, then pull reset in the middle of a cycle.
    drive(1'b1, 1'b0, 1'b0, 4'd5);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.state !== 4'd5 || bus.busy !== 1'b1) begin
      err_count++; $display("FAIL reset_setup: got state=%0d busy=%b want 5 1", bus.state, bus.busy);
    end
    bus.count = 1'b1;
    reset_n   = 1'b0;
    #1;
    vec_count++;
    if (bus.state !== 4'd0) begin err_count++; $display("FAIL async_reset_state: got %0d want 0", bus.state); end
    vec_count++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.borrow !== 1'b0) begin
      err_count++; $display("FAIL async_reset_flags: got busy=%b done=%b borrow=%b want 0 0 0", bus.busy, bus.done, bus.borrow);
    end
    @(negedge clock);
    bus.count = 1'b0;
    reset_n   = 1'b1;
  endtask

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_periodic;
    logic [W-1:0] exp_state [6];
    exp_state = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0};
    drive(1'b1, 1'b0, 1'b0, 4'd2);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      vec_count++;
      if (bus.state !== exp_state[k]) begin
        err_count++; $display("FAIL periodic_state[%0d]: got %0d want %0d", k, bus.state, exp_state[k]);
      end
      vec_count++;
      if (bus.borrow !== (k % 3 == 2)) begin
        err_count++; $display("FAIL periodic_borrow[%0d]: got %b want %b", k, bus.borrow, (k % 3 == 2));
      end
      vec_count++;
      if (bus.done !== (k == 3)) begin
        err_count++; $display("FAIL periodic_done[%0d]: got %b want %b", k, bus.done, (k == 3));
      end
      vec_count++;
      if (bus.busy !== 1'b1) begin err_count++; $display("FAIL periodic_busy[%0d]: got %b want 1", k, bus.busy); end
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.state !== 4'd2) begin
      err_count++; $display("FAIL periodic_tail: got done=%b busy=%b state=%0d want 1 1 2", bus.done, bus.busy, bus.state);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
  endtask
`else
  task automatic test_oneshot;
    drive(1'b1, 1'b0, 1'b0, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    vec_count++;
    if (bus.state !== 4'd3 || bus.busy !== 1'b0) begin
      err_count++; $display("FAIL oneshot_armed: got state=%0d busy=%b want 3 0", bus.state, bus.busy);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      vec_count++;
      if (bus.state !== 4'(3 - k)) begin
        err_count++; $display("FAIL oneshot_state[%0d]: got %0d want %0d", k, bus.state, 3 - k);
      end
      vec_count++;
      if (bus.borrow !== (k == 3) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        err_count++; $display("FAIL oneshot_flags[%0d]: got borrow=%b busy=%b done=%b want %b 1 0", k, bus.borrow, bus.busy, bus.done, (k == 3));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    vec_count++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.state !== 4'd0 || bus.borrow !== 1'b0) begin
      err_count++; $display("FAIL oneshot_done: got done=%b busy=%b state=%0d borrow=%b want 1 0 0 0", bus.done, bus.busy, bus.state, bus.borrow);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.done !== 1'b0 || bus.state !== 4'd0) begin
      err_count++; $display("FAIL oneshot_done_clear: got done=%b state=%0d want 0 0", bus.done, bus.state);
    end
    // Re-arm from zero: the first tick after start is terminal.
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    vec_count++;
    if (bus.borrow !== 1'b1 || bus.busy !== 1'b1) begin
      err_count++; $display("FAIL oneshot_rearm: got borrow=%b busy=%b want 1 1", bus.borrow, bus.busy);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      err_count++; $display("FAIL oneshot_rearm_done: got done=%b busy=%b want 1 0", bus.done, bus.busy);
    end
  endtask
`endif

  task automatic test_gated_ticks;
    drive(1'b1, 1'b0, 1'b0, 4'd4);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, (i % 2 == 0), 4'd0);
      vec_count++;
      if (bus.state !== 4'(4 - (i + 1) / 2)) begin
        err_count++; $display("FAIL gated_state[%0d]: got %0d want %0d", i, bus.state, 4 - (i + 1) / 2);
      end
      vec_count++;
      if (bus.borrow !== (i == 8)) begin
        err_count++; $display("FAIL gated_borrow[%0d]: got %b want %b", i, bus.borrow, (i == 8));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.done !== 1'b1) begin err_count++; $display("FAIL gated_done: got %b want 1", bus.done); end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_priority;
    // Load collides with a terminal tick.
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b1, 4'd9);
    vec_count++;
    if (bus.borrow !== 1'b1) begin err_count++; $display("FAIL prio_borrow: got %b want 1", bus.borrow); end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.state !== 4'd9 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      err_count++; $display("FAIL prio_load_wins: got state=%0d busy=%b done=%b want 9 0 0", bus.state, bus.busy, bus.done);
    end
    // Start while already running at 6 changes nothing.
    drive(1'b1, 1'b0, 1'b0, 4'd6);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.state !== 4'd6 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      err_count++; $display("FAIL prio_start_in_run: got state=%0d busy=%b done=%b want 6 1 0", bus.state, bus.busy, bus.done);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_back_to_back;
    // Start and count in the same idle cycle: the tick is not taken.
    drive(1'b1, 1'b0, 1'b0, 4'd2);
    drive(1'b0, 1'b1, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    vec_count++;
    if (bus.state !== 4'd2 || bus.busy !== 1'b1) begin
      err_count++; $display("FAIL start_with_count: got state=%0d busy=%b want 2 1", bus.state, bus.busy);
    end
    drive(1'b1, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_idle_safety;
    drive(1'b1, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd0);
      vec_count++;
      if (bus.state !== 4'd7 || bus.borrow !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        err_count++; $display("FAIL idle_safety[%0d]: got state=%0d borrow=%b done=%b busy=%b want 7 0 0 0", i, bus.state, bus.borrow, bus.done, bus.busy);
      end
    end
  endtask

  initial begin
    vec_count = 0;
    err_count = 0;
    reset_n   = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.count = 1'b0;
    bus.ins   = '0;
    #2;
    test_reset;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    test_periodic;
`else
    test_oneshot;
`endif
    test_gated_ticks;
    test_priority;
    test_back_to_back;
    test_idle_safety;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
